wifi_tx_frame_ctrl: RTL and testbench
=====================================

WIFI_TX_FRAME_CTRL -- requirements
Module: WIFI_TX_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 400: maximum number of cycles a phase may wait for its done pulse; range 2..1023.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 abort  input  1  cancels the frame from any state.
REQ-006 n_sym  input  8  number of DATA symbols; latched on accepted start.
REQ-007 done_in  input  4  done pulse per source: [0] STP (short preamble), [1] LTP, [2] SIG, [3] DATA symbol.
REQ-008 in_re, in_im  input  48 each  four 12-bit sample buses, source k at bits [12k+11:12k].
REQ-009 in_valid  input  4  sample valid per source.
REQ-010 start_out  output  4  one-cycle start pulse per source, one-hot.
REQ-011 out_re, out_im  output  12 each  muxed sample stream.
REQ-012 out_valid  output  1  qualifies out_re/out_im.
REQ-013 busy  output  1  high in STP, LTP, SIG and DATA.
REQ-014 frame_done  output  1  one-cycle pulse at normal frame end.
REQ-015 err  output  1  phase timeout flag.
REQ-016 sym_cnt  output  8  DATA symbols completed in the current frame.

Function
REQ-017 The block SHALL implement the states IDLE, STP, LTP, SIG, DATA, DONE and ERR.
REQ-018 In IDLE, a cycle with start=1 and abort=0 SHALL latch n_sym, clear sym_cnt, move to STP and assert start_out[0] for exactly the first cycle in STP.
REQ-019 Each phase p SHALL follow STP(0)->LTP(1)->SIG(2)->DATA(3); on done_in[p]=1 the block SHALL move to the next phase and pulse start_out[next] for one cycle, coincident with the first cycle of that phase.
REQ-020 The block SHALL ignore done_in bits of non-active sources.
REQ-021 If the latched n_sym equals 0, SIG done SHALL go directly to DONE, with no start_out[3] pulse.
REQ-022 In DATA, each done_in[3] SHALL increment sym_cnt; the 8-bit sym_cnt SHALL not wrap.
REQ-023 In DATA, when the incremented sym_cnt equals the latched n_sym the block SHALL go to DONE; otherwise it SHALL re-pulse start_out[3] on the next cycle and remain in DATA.
REQ-024 DONE SHALL last one cycle, assert frame_done and return to IDLE; busy SHALL be low in DONE.
REQ-025 Output mux: in phase p, out_re, out_im and out_valid SHALL be registered copies of source p's in_re, in_im and in_valid (1-cycle latency).
REQ-026 Outside STP..DATA, out_valid SHALL be 0 and out_re/out_im SHALL be 0.
REQ-027 Watchdog: a 10-bit counter SHALL clear on every phase entry, including each DATA symbol restart, and increment each cycle otherwise.
REQ-028 If the watchdog reaches TIMEOUT-1 without the active done, the block SHALL go to ERR and set err=1.
REQ-029 If done and the watchdog limit occur in the same cycle, done SHALL take priority.
REQ-030 ERR SHALL hold out_valid=0, busy=0 and err=1, and SHALL ignore start; only abort or reset SHALL exit ERR.
REQ-031 abort=1 in any state SHALL move to IDLE on the next edge, clear err, pulse no start_out, and assert no frame_done.
REQ-032 abort SHALL take priority over start, done and timeout.
REQ-033 start while not in IDLE SHALL be ignored and SHALL not be queued.

Reset
REQ-034 While reset=1, the block SHALL be in IDLE with all outputs 0, sym_cnt=0, watchdog=0 and latched n_sym=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame immediately, asynchronously, with no frame_done.
REQ-036 After reset deasserts, the block SHALL require a new start.

Verification
REQ-037 Scenario 1: start with n_sym=2, done_in pulses [0],[1],[2],[3],[3] -> start_out sequence 1,2,4,8,8; sym_cnt 0->1->2; frame_done one cycle after the second DATA done; busy then 0.
REQ-038 Scenario 2: n_sym=0 -> after SIG done the block goes to DONE; start_out[3] never pulses; sym_cnt stays 0.
REQ-039 Scenario 3: in LTP, drive in_valid=4'b0011, in_re[23:12]=12'h7F0 -> next cycle out_valid=1, out_re=12'h7F0; source 0 data does not appear on the outputs.
REQ-040 Scenario 4: TIMEOUT=8, no done in SIG -> err=1 after 8 cycles; a start in ERR is ignored; abort returns the block to IDLE with err=0.
REQ-041 Scenario 5: done_in[1] and the watchdog limit in the same LTP cycle -> the block moves to SIG and err stays 0.
REQ-042 Scenario 6: reset=1 during DATA with sym_cnt=3 -> all outputs 0 immediately; no frame_done; a start after reset releases begins a fresh STP.

Source files
------------

// File: rtl/wifi_tx_frame_ctrl.sv
// rtl/wifi_tx_frame_ctrl.sv - Wi-Fi transmit frame sequencer (STP, LTP, SIG, DATA) with sample mux and watchdog
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   start, abort      frame request (honoured in IDLE only) / cancel from any state
//   n_sym[7:0]        DATA symbol count, latched on accepted start
//   done_in[3:0]      per-source done pulses: [0] STP, [1] LTP, [2] SIG, [3] DATA symbol
//   in_re, in_im      four 12-bit sample buses, source k at [12k+11:12k]
//   in_valid[3:0]     per-source sample valid
//   start_out[3:0]    one-hot, one-cycle start pulse to the source entering its phase
//   out_re, out_im    registered sample stream of the active source
//   out_valid         qualifies out_re/out_im
//   busy              high in STP, LTP, SIG and DATA
//   frame_done        one-cycle pulse on normal frame end
//   err               phase watchdog expired; held until abort or reset
//   sym_cnt[7:0]      DATA symbols completed in the current frame

module wifi_tx_frame_ctrl #(
  parameter int TIMEOUT = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  n_sym,
  input  logic [3:0]  done_in,
  input  logic [47:0] in_re,
  input  logic [47:0] in_im,
  input  logic [3:0]  in_valid,
  output logic [3:0]  start_out,
  output logic [11:0] out_re,
  output logic [11:0] out_im,
  output logic        out_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        err,
  output logic [7:0]  sym_cnt
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] STP  = 3'd1;
  localparam logic [2:0] LTP  = 3'd2;
  localparam logic [2:0] SIG  = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;

  localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [7:0]  n_sym_q;
  logic [9:0]  wdog;
  logic [3:0]  start_q;
  logic [11:0] re_q;
  logic [11:0] im_q;
  logic        valid_q;

  logic [1:0]  phase;
  logic        act_done;
  logic        wd_limit;
  logic [7:0]  sym_inc;

  // Source index of the active phase; only meaningful while busy.
  always_comb begin
    phase = 2'd0;
    case (state)
      LTP:     phase = 2'd1;
      SIG:     phase = 2'd2;
      DATA:    phase = 2'd3;
      default: phase = 2'd0;
    endcase
  end

  assign busy     = (state == STP) || (state == LTP) || (state == SIG) || (state == DATA);
  assign act_done = busy && done_in[phase];
  assign wd_limit = (wdog == WD_LIMIT);
  assign sym_inc  = (sym_cnt == 8'hFF) ? 8'hFF : sym_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      n_sym_q <= '0;
      sym_cnt <= '0;
      wdog    <= '0;
      start_q <= '0;
      re_q    <= '0;
      im_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      start_q <= '0;

      if (busy) begin
        re_q    <= in_re[12*phase +: 12];
        im_q    <= in_im[12*phase +: 12];
        valid_q <= in_valid[phase];
      end else begin
        re_q    <= '0;
        im_q    <= '0;
        valid_q <= 1'b0;
      end

      if (abort) begin
        state <= IDLE;
        wdog  <= '0;
      end else begin
        case (state)
          IDLE: begin
            wdog <= '0;
            if (start) begin
              n_sym_q <= n_sym;
              sym_cnt <= '0;
              state   <= STP;
              start_q <= 4'b0001;
            end
          end
          STP, LTP, SIG, DATA: begin
            // Done beats the watchdog when both land in the same cycle.
            if (act_done) begin
              wdog <= '0;
              case (state)
                STP: begin
                  state   <= LTP;
                  start_q <= 4'b0010;
                end
                LTP: begin
                  state   <= SIG;
                  start_q <= 4'b0100;
                end
                SIG: begin
                  if (n_sym_q == 8'd0) begin
                    state <= DONE;
                  end else begin
                    state   <= DATA;
                    start_q <= 4'b1000;
                  end
                end
                default: begin
                  sym_cnt <= sym_inc;
                  if (sym_inc == n_sym_q) begin
                    state <= DONE;
                  end else begin
                    start_q <= 4'b1000;
                  end
                end
              endcase
            end else if (wd_limit) begin
              state <= ERR;
              wdog  <= '0;
            end else begin
              wdog <= wdog + 10'd1;
            end
          end
          DONE: begin
            wdog  <= '0;
            state <= IDLE;
          end
          ERR: begin
            wdog <= '0;
          end
          default: begin
            wdog  <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // The mux registers lag the state by one cycle, so gate with busy to keep
  // the stream quiet in DONE/ERR/IDLE.
  assign out_re     = busy ? re_q : 12'd0;
  assign out_im     = busy ? im_q : 12'd0;
  assign out_valid  = busy & valid_q;
  assign start_out  = start_q;
  assign frame_done = (state == DONE);
  assign err        = (state == ERR);

endmodule

// File: tb/tb_wifi_tx_frame_ctrl.sv
// tb/tb_wifi_tx_frame_ctrl.sv - directed self-checking bench for wifi_tx_frame_ctrl

module tb_wifi_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  n_sym;
  logic [3:0]  done_in;
  logic [47:0] in_re;
  logic [47:0] in_im;
  logic [3:0]  in_valid;
  logic [3:0]  start_out;
  logic [11:0] out_re;
  logic [11:0] out_im;
  logic        out_valid;
  logic        busy;
  logic        frame_done;
  logic        err;
  logic [7:0]  sym_cnt;

  int checks = 0;
  int errors = 0;

  wifi_tx_frame_ctrl #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .n_sym      (n_sym),
    .done_in    (done_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_valid   (in_valid),
    .start_out  (start_out),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .sym_cnt    (sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; n_sym = 8'd0;
    done_in = 4'd0; in_re = '0; in_im = '0; in_valid = 4'd0;
    repeat (2) step();
    check("rst_start_out", 32'(start_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sym_cnt", 32'(sym_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk); reset = 1'b0;
    step();

    // Scenario 1: n_sym=2 full frame
    start = 1'b1; n_sym = 8'd2; step(); start = 1'b0;
    check("s1_stp_pulse", 32'(start_out), 32'h1);
    check("s1_stp_busy", 32'(busy), 32'h1);
    done_in = 4'b0001; step();
    check("s1_ltp_pulse", 32'(start_out), 32'h2);
    done_in = 4'b1101; step();
    check("s1_ltp_ignore_other", 32'(start_out), 32'h0);
    check("s1_ltp_still_busy", 32'(busy), 32'h1);
    done_in = 4'b0010; step();
    check("s1_sig_pulse", 32'(start_out), 32'h4);
    done_in = 4'b0100; step();
    check("s1_data_pulse", 32'(start_out), 32'h8);
    check("s1_sym0", 32'(sym_cnt), 32'h0);
    done_in = 4'b1000; step();
    check("s1_sym1", 32'(sym_cnt), 32'h1);
    check("s1_data_repulse", 32'(start_out), 32'h8);
    check("s1_no_done_yet", 32'(frame_done), 32'h0);
    done_in = 4'b0000; step();
    check("s1_pulse_one_cycle", 32'(start_out), 32'h0);
    done_in = 4'b1000; step();
    check("s1_sym2", 32'(sym_cnt), 32'h2);
    check("s1_frame_done", 32'(frame_done), 32'h1);
    check("s1_done_busy", 32'(busy), 32'h0);
    check("s1_done_no_pulse", 32'(start_out), 32'h0);
    done_in = 4'b0000; step();
    check("s1_frame_done_clear", 32'(frame_done), 32'h0);
    check("s1_idle_busy", 32'(busy), 32'h0);

    // Scenario 2: n_sym=0 skips DATA
    start = 1'b1; n_sym = 8'd0; step(); start = 1'b0;
    check("s2_stp_pulse", 32'(start_out), 32'h1);
    done_in = 4'b0001; step();
    done_in = 4'b0010; step();
    done_in = 4'b0100; step();
    check("s2_frame_done", 32'(frame_done), 32'h1);
    check("s2_no_data_pulse", 32'(start_out), 32'h0);
    check("s2_sym_cnt", 32'(sym_cnt), 32'h0);
    done_in = 4'b0000; step();
    check("s2_idle", 32'(busy), 32'h0);

    // Scenario 3: output mux in LTP selects source 1
    start = 1'b1; n_sym = 8'd1; step(); start = 1'b0;
    done_in = 4'b0001; step(); done_in = 4'b0000;
    in_valid = 4'b0011;
    in_re = {24'h0, 12'h7F0, 12'h123};
    in_im = {24'h0, 12'h0A5, 12'h456};
    step();
    check("s3_out_valid", 32'(out_valid), 32'h1);
    check("s3_out_re", 32'(out_re), 32'h7F0);
    check("s3_out_im", 32'(out_im), 32'h0A5);
    in_valid = 4'b0001; step();
    check("s3_src0_not_shown", 32'(out_valid), 32'h0);
    in_valid = 4'b0000; in_re = '0; in_im = '0;
    abort = 1'b1; done_in = 4'b0010; step(); abort = 1'b0; done_in = 4'b0000;
    check("s3_abort_idle", 32'(busy), 32'h0);
    check("s3_abort_no_pulse", 32'(start_out), 32'h0);
    check("s3_abort_out_valid", 32'(out_valid), 32'h0);

    // Scenario 4: SIG watchdog (TIMEOUT=8)
    start = 1'b1; n_sym = 8'd1; step(); start = 1'b0;
    done_in = 4'b0001; step();
    done_in = 4'b0010; step(); done_in = 4'b0000;
    check("s4_sig_pulse", 32'(start_out), 32'h4);
    repeat (7) step();
    check("s4_before_limit_err", 32'(err), 32'h0);
    check("s4_before_limit_busy", 32'(busy), 32'h1);
    step();
    check("s4_err_set", 32'(err), 32'h1);
    check("s4_err_busy", 32'(busy), 32'h0);
    start = 1'b1; step();
    check("s4_start_ignored_err", 32'(err), 32'h1);
    check("s4_start_ignored_pulse", 32'(start_out), 32'h0);
    abort = 1'b1; step(); abort = 1'b0; start = 1'b0;
    check("s4_abort_clears_err", 32'(err), 32'h0);
    check("s4_abort_over_start", 32'(start_out), 32'h0);
    step();
    check("s4_start_not_queued", 32'(busy), 32'h0);

    // Scenario 5: LTP done coincides with watchdog limit
    start = 1'b1; n_sym = 8'd1; step(); start = 1'b0;
    done_in = 4'b0001; step(); done_in = 4'b0000;
    repeat (7) step();
    check("s5_in_ltp", 32'(busy), 32'h1);
    done_in = 4'b0010; step(); done_in = 4'b0000;
    check("s5_done_wins_err", 32'(err), 32'h0);
    check("s5_sig_pulse", 32'(start_out), 32'h4);
    // abort also wins over a done in the same cycle
    abort = 1'b1; done_in = 4'b0100; step(); abort = 1'b0; done_in = 4'b0000;
    check("s5_abort_over_done", 32'(start_out), 32'h0);
    check("s5_abort_idle", 32'(busy), 32'h0);

    // Scenario 6: reset in DATA with sym_cnt=3
    start = 1'b1; n_sym = 8'd5; step(); start = 1'b0;
    done_in = 4'b0001; step();
    done_in = 4'b0010; step();
    done_in = 4'b0100; step();
    done_in = 4'b1000; repeat (3) step(); done_in = 4'b0000;
    check("s6_sym3", 32'(sym_cnt), 32'h3);
    in_valid = 4'b1000; in_re = {12'hABC, 36'h0}; step();
    check("s6_data_out_re", 32'(out_re), 32'hABC);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_busy", 32'(busy), 32'h0);
    check("s6_rst_sym_cnt", 32'(sym_cnt), 32'h0);
    check("s6_rst_out_valid", 32'(out_valid), 32'h0);
    check("s6_rst_out_re", 32'(out_re), 32'h0);
    check("s6_rst_frame_done", 32'(frame_done), 32'h0);
    in_valid = 4'b0000; in_re = '0;
    @(negedge clk); reset = 1'b0;
    step();
    check("s6_post_rst_idle", 32'(busy), 32'h0);
    check("s6_post_rst_no_done", 32'(frame_done), 32'h0);
    start = 1'b1; n_sym = 8'd1; step(); start = 1'b0;
    check("s6_fresh_stp_pulse", 32'(start_out), 32'h1);
    check("s6_fresh_sym_cnt", 32'(sym_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
